imem_loader_ctrl: RTL and testbench
===================================

# imem_loader_ctrl

Sequencing controller that loads a program into the single-cycle CPU's instruction memory from a byte stream, such as a UART receiver or debug host. It holds the CPU in stall while loading. It assembles big-endian bytes into 32-bit words and drives the instruction memory write port with sequential word addresses starting at 0. When the load finishes, it releases the CPU with a one-cycle PC-reset pulse.

## Interface
- DEPTH, 128, instruction memory depth in words
- AW, 7, word-address width; AW must satisfy 2^AW = DEPTH
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- load_req  in  1  single-cycle start request; sampled only in IDLE
- load_words  in  AW+1  number of words to load, captured with load_req; legal range 1..DEPTH
- load_abort  in  1  cancels an active load; sampled in RECV, WRITE and CKSUM
- byte_valid  in  1  byte stream valid
- byte_data  in  8  byte stream data
- byte_ready  out  1  controller accepts a byte this cycle
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_waddr  out  AW  word address of the write
- mem_wdata  out  32  assembled word
- cpu_stall  out  1  freezes PC and register/data-memory writes
- cpu_pc_reset  out  1  one-cycle pulse that forces PC to 0
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag; cleared when the next load_req is accepted

## Operation
- States: IDLE, RECV, WRITE, CKSUM, FINISH.
- IDLE:
  - On load_req with 1 ≤ load_words ≤ DEPTH: capture the count, clear word address, byte index and err, then go to RECV.
  - On load_req with load_words = 0 or load_words > DEPTH: set err and stay in IDLE. No stall, no write.
  - load_req outside IDLE is ignored.
- RECV:
  - byte_ready = 1.
  - A byte transfers when byte_valid && byte_ready.
  - The first byte of a word goes to bits [31:24], then [23:16], then [15:8], then [7:0].
  - On the 4th transfer, go to WRITE.
- WRITE:
  - byte_ready = 0.
  - mem_we = 1, mem_waddr = current word index, mem_wdata = assembled word.
  - Then increment the word index.
  - If this was the last word, go to CKSUM (macro defined) or FINISH (macro not defined). Otherwise return to RECV.
- CKSUM: see Configuration.
- FINISH:
  - cpu_pc_reset = 1 and done = 1 for this cycle, then go to IDLE.
- Abort:
  - load_abort in RECV, WRITE or CKSUM goes to IDLE and sets err.
  - Abort has priority over any byte transfer or write in the same cycle: mem_we = 0 in that cycle.
  - Words already written remain in memory.
- cpu_stall = 1 in RECV, WRITE, CKSUM and FINISH, and 0 in IDLE.
- The word index never wraps: a load of DEPTH words writes addresses 0..DEPTH-1 exactly once.

## Timing
- Reset values: state = IDLE and every output = 0. Internal counters and the shift register are cleared. Memory contents are not affected.
- The first RECV cycle, with byte_ready = 1, is the cycle after load_req.
- mem_we is asserted the cycle after the 4th byte transfer.
- With back-to-back bytes, each word takes 5 cycles: 4 RECV cycles and 1 WRITE cycle.
- A load of N words with no gaps and no checksum runs 5N+1 cycles from the first RECV cycle to the FINISH cycle inclusive.
- cpu_stall deasserts in the cycle after FINISH.
- byte_valid low inserts wait cycles; partial-word state is held.
- rst mid-load aborts immediately. err is not set (it is reset to 0). The partial word is discarded.

## Configuration
- IMEM_LOAD_CHECKSUM_EN defined:
  - After the last WRITE, go to CKSUM with byte_ready = 1.
  - Accept one byte and compare it with the XOR of all data bytes of this load.
  - On a match, go to FINISH.
  - On a mismatch, set err, go to IDLE, and issue no cpu_pc_reset or done. cpu_stall deasserts.
- IMEM_LOAD_CHECKSUM_EN not defined:
  - The CKSUM state and the XOR accumulator are not built.
  - WRITE of the last word goes directly to FINISH.

## Test plan
- Nominal load:
  - Stimulus: load_words=2; bytes 20 08 00 07 20 09 00 09, back-to-back.
  - Response: mem_we at addr 0 with 0x20080007, then at addr 1 with 0x20090009. done and cpu_pc_reset pulse on cycle 11 after load_req. err=0.
- Gapped stream:
  - Stimulus: same data with byte_valid low for 3 cycles between bytes.
  - Response: identical writes, no extra mem_we, cpu_stall held high throughout.
- Illegal count:
  - Stimulus: load_words=0, then load_words=DEPTH+1.
  - Response: err=1, busy=0 and cpu_stall=0 throughout, no mem_we.
- Abort:
  - Stimulus: load_words=3; abort after the 6th byte.
  - Response: exactly one write (addr 0), err=1, IDLE on the next cycle, no done.
- Reset mid-load:
  - Stimulus: assert rst asynchronously during the 2nd word.
  - Response: all outputs go to 0 immediately. A new load of 1 word, bytes AE 0A 00 00, then writes 0xAE0A0000 to addr 0.
- With IMEM_LOAD_CHECKSUM_EN defined:
  - Stimulus: 1 word 20 08 00 07, then checksum 0x2F.
  - Response: done pulse.
  - Stimulus: repeat with checksum 0x00.
  - Response: err=1 and no cpu_pc_reset.

Source files
------------

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl
//
// Loads a program into the instruction memory of a single-cycle CPU from a
// byte stream (UART receiver, debug host). While loading, the CPU is held in
// stall. Bytes are assembled big-endian into 32-bit words. The words are written
// to sequential word addresses starting at 0. A successful load ends with a
// one-cycle PC-reset pulse, which releases the CPU.
//
// Optional feature: define IMEM_LOAD_CHECKSUM_EN to add a trailing checksum
// byte. The checksum is the XOR of all data bytes. A mismatch flags err and
// the CPU is not released.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   load_req      single-cycle start request (honoured only when idle)
//   load_words    number of words to load, legal range 1..DEPTH
//   load_abort    cancels an active load
//   byte_valid    byte stream valid
//   byte_data     byte stream data
//   byte_ready    controller accepts a byte this cycle
//   mem_we        instruction memory write enable (one cycle per word)
//   mem_waddr     word address of the write
//   mem_wdata     assembled 32-bit word
//   cpu_stall     freezes PC and register/data-memory writes
//   cpu_pc_reset  one-cycle pulse forcing PC to 0
//   busy          controller is not idle
//   done          one-cycle pulse on successful completion
//   err           sticky error; cleared when the next load is accepted

module imem_loader_ctrl #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic [AW:0]   load_words,
    input  logic          load_abort,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_stall,
    output logic          cpu_pc_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
    localparam logic [AW:0] OneW   = (AW+1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
`ifdef IMEM_LOAD_CHECKSUM_EN
        StCksum,
`endif
        StFinish
    } state_e;

    state_e        state_q;
    logic [AW:0]   words_q;     // captured word count
    logic [AW-1:0] word_idx_q;  // address of the word being assembled
    logic [1:0]    byte_idx_q;  // byte position within the current word
    logic [31:0]   shift_q;     // big-endian assembly register
    logic          err_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]    cksum_q;     // running XOR of this load's data bytes
`endif

    logic last_word;
    logic req_illegal;

    assign last_word   = ({1'b0, word_idx_q} == (words_q - OneW));
    assign req_illegal = (load_words == '0) || (load_words > DepthW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            words_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            err_q      <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_req) begin
                        if (req_illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            words_q    <= load_words;
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                            err_q      <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                            cksum_q    <= '0;
`endif
                            state_q    <= StRecv;
                        end
                    end
                end

                StRecv: begin
                    // Abort wins over a byte offered in the same cycle.
                    if (load_abort) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (byte_valid) begin
                        shift_q    <= {shift_q[23:0], byte_data};
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        cksum_q    <= cksum_q ^ byte_data;
`endif
                        if (byte_idx_q == 2'd3) begin
                            state_q <= StWrite;
                        end
                    end
                end

                StWrite: begin
                    if (load_abort) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (last_word) begin
                        // Index is not advanced past the last word, so it never wraps.
`ifdef IMEM_LOAD_CHECKSUM_EN
                        state_q <= StCksum;
`else
                        state_q <= StFinish;
`endif
                    end else begin
                        word_idx_q <= word_idx_q + AW'(1);
                        state_q    <= StRecv;
                    end
                end

`ifdef IMEM_LOAD_CHECKSUM_EN
                StCksum: begin
                    if (load_abort) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (byte_valid) begin
                        if (byte_data == cksum_q) begin
                            state_q <= StFinish;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
`endif

                StFinish: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs are decoded from the state register only, except mem_we. It is
    // gated by load_abort so that an abort in WRITE suppresses the write.
    always_comb begin
        byte_ready   = 1'b0;
        mem_we       = 1'b0;
        cpu_pc_reset = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            StRecv:   byte_ready = 1'b1;
            StWrite:  mem_we     = ~load_abort;
`ifdef IMEM_LOAD_CHECKSUM_EN
            StCksum:  byte_ready = 1'b1;
`endif
            StFinish: begin
                cpu_pc_reset = 1'b1;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_waddr = word_idx_q;
    assign mem_wdata = shift_q;
    assign cpu_stall = (state_q != StIdle);
    assign busy      = (state_q != StIdle);
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
module tb_imem_loader_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
`ifdef IMEM_LOAD_CHECKSUM_EN
    localparam int CkExtra = 1;
`else
    localparam int CkExtra = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic [AW:0]   load_words;
    logic          load_abort;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_stall;
    logic          cpu_pc_reset;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .load_words(load_words),
        .load_abort(load_abort), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .cpu_stall(cpu_stall), .cpu_pc_reset(cpu_pc_reset),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int req_cyc = 0;

    // Monitor samples at mid-cycle, away from the active edge.
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int done_cnt, pcr_cnt, done_cyc, stall_low, busy_hi, stall_hi;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_waddr);
            wr_data.push_back(mem_wdata);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cpu_pc_reset) pcr_cnt++;
        if (!cpu_stall) stall_low++;
        if (busy) busy_hi++;
        if (cpu_stall) stall_hi++;
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0; pcr_cnt = 0; stall_low = 0; busy_hi = 0; stall_hi = 0; done_cyc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW:0] n);
        load_req = 1'b1;
        load_words = n;
        req_cyc = cyc;
        step();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        byte_valid = 1'b1;
        byte_data = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_byte: byte %h never accepted, byte_ready=%b want 1", b, byte_ready);
        end
        repeat (gap) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; load_req = 0; load_words = '0; load_abort = 0; byte_valid = 0; byte_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({byte_ready, mem_we, cpu_stall, cpu_pc_reset, busy, done, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {byte_ready, mem_we, cpu_stall, cpu_pc_reset, busy, done, err});
        end
        checks++;
        if ({mem_waddr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_mem: addr %h data %h want 0", mem_waddr, mem_wdata);
        end
        rst = 1'b0;
        step();
    endtask

    // Two-word program shared by the nominal and gapped scenarios.
    task automatic run_two_word(input int gap, input string tag);
        logic [7:0] b [8] = '{8'h20, 8'h08, 8'h00, 8'h07, 8'h20, 8'h09, 8'h00, 8'h09};
        clear_mon();
        start_load(2);
        stall_low = 0;
        checks++;
        if ({byte_ready, busy, cpu_stall, err} !== 4'b1110) begin
            errors++; $display("FAIL %s_first_recv: got %b want 1110", tag,
                               {byte_ready, busy, cpu_stall, err});
        end
        for (int i = 0; i < 8; i++) send_byte(b[i], (i < 7) ? gap : 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(8'h0F, 0);
`else
        step();
`endif
        checks++;
        if ({done, cpu_pc_reset, cpu_stall} !== 3'b111) begin
            errors++; $display("FAIL %s_finish: done/pcr/stall got %b want 111", tag,
                               {done, cpu_pc_reset, cpu_stall});
        end
        checks++;
        if (stall_low !== 0) begin
            errors++; $display("FAIL %s_stall_held: low cycles got %0d want 0", tag, stall_low);
        end
        step();
        checks++;
        if ({cpu_stall, busy, done, err} !== 4'b0000) begin
            errors++; $display("FAIL %s_idle: stall/busy/done/err got %b want 0000", tag,
                               {cpu_stall, busy, done, err});
        end
        checks++;
        if (wr_addr.size() !== 2) begin
            errors++; $display("FAIL %s_wr_count: got %0d want 2", tag, wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 7'd0 || wr_data[0] !== 32'h20080007) begin
                errors++; $display("FAIL %s_wr0: got %h:%h want 00:20080007", tag,
                                   wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 7'd1 || wr_data[1] !== 32'h20090009) begin
                errors++; $display("FAIL %s_wr1: got %h:%h want 01:20090009", tag,
                                   wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (done_cnt !== 1 || pcr_cnt !== 1) begin
            errors++; $display("FAIL %s_pulses: done %0d pcr %0d want 1 1", tag, done_cnt, pcr_cnt);
        end
        if (gap == 0) begin
            checks++;
            if (done_cyc - req_cyc !== 11 + CkExtra) begin
                errors++; $display("FAIL %s_done_cycle: got %0d want %0d", tag,
                                   done_cyc - req_cyc, 11 + CkExtra);
            end
        end
    endtask

    task automatic test_nominal();
        run_two_word(0, "nominal");
    endtask

    task automatic test_gapped();
        run_two_word(3, "gapped");
    endtask

    task automatic test_illegal();
        clear_mon();
        start_load(0);
        checks++;
        if ({err, busy, cpu_stall} !== 3'b100) begin
            errors++; $display("FAIL illegal0: err/busy/stall got %b want 100", {err, busy, cpu_stall});
        end
        rst = 1'b1; step(); rst = 1'b0; step();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL illegal_rst_err: got %b want 0", err);
        end
        start_load(DEPTH + 1);
        checks++;
        if ({err, busy, cpu_stall} !== 3'b100) begin
            errors++; $display("FAIL illegal129: err/busy/stall got %b want 100", {err, busy, cpu_stall});
        end
        repeat (2) step();
        checks++;
        if (busy_hi !== 0 || stall_hi !== 0 || wr_addr.size() !== 0) begin
            errors++; $display("FAIL illegal_quiet: busy %0d stall %0d writes %0d want 0 0 0",
                               busy_hi, stall_hi, wr_addr.size());
        end
    endtask

    task automatic test_full_depth();
        logic [7:0]  ck = 8'h00;
        logic [7:0]  wb;
        logic [31:0] exp;
        int bad = 0;
        clear_mon();
        start_load(DEPTH);  // err is still set from the illegal request
        checks++;
        if ({err, byte_ready} !== 2'b01) begin
            errors++; $display("FAIL full_accept: err/ready got %b want 01", {err, byte_ready});
        end
        for (int w = 0; w < DEPTH; w++) begin
            wb = 8'(w);
            exp = {wb, ~wb, 8'hA5, wb ^ 8'h3C};
            for (int k = 3; k >= 0; k--) begin
                send_byte(exp[k*8 +: 8], 0);
                ck = ck ^ exp[k*8 +: 8];
            end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(ck, 0);
`else
        step();
`endif
        step();
        checks++;
        if (wr_addr.size() !== DEPTH) begin
            errors++; $display("FAIL full_wr_count: got %0d want %0d", wr_addr.size(), DEPTH);
        end else begin
            for (int w = 0; w < DEPTH; w++) begin
                wb = 8'(w);
                exp = {wb, ~wb, 8'hA5, wb ^ 8'h3C};
                checks++;
                if ((wr_addr[w] !== 7'(w) || wr_data[w] !== exp) && bad < 4) begin
                    bad++; errors++;
                    $display("FAIL full_wr%0d: got %h:%h want %h:%h", w, wr_addr[w], wr_data[w],
                             7'(w), exp);
                end else if (wr_addr[w] !== 7'(w) || wr_data[w] !== exp) begin
                    errors++;
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc - req_cyc !== 5 * DEPTH + 1 + CkExtra) begin
            errors++; $display("FAIL full_done: count %0d cycle %0d want 1 %0d", done_cnt,
                               done_cyc - req_cyc, 5 * DEPTH + 1 + CkExtra);
        end
    endtask

    task automatic test_abort_recv();
        logic [7:0] b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        clear_mon();
        start_load(3);
        for (int i = 0; i < 6; i++) send_byte(b[i], 0);
        load_abort = 1'b1; byte_valid = 1'b1; byte_data = 8'h77;
        step();
        load_abort = 1'b0; byte_valid = 1'b0;
        checks++;
        if ({busy, cpu_stall, err} !== 3'b001) begin
            errors++; $display("FAIL abort_recv_idle: busy/stall/err got %b want 001",
                               {busy, cpu_stall, err});
        end
        repeat (2) step();
        checks++;
        if (wr_addr.size() !== 1 || done_cnt !== 0 || pcr_cnt !== 0) begin
            errors++; $display("FAIL abort_recv_writes: writes %0d done %0d pcr %0d want 1 0 0",
                               wr_addr.size(), done_cnt, pcr_cnt);
        end else begin
            checks++;
            if (wr_addr[0] !== 7'd0 || wr_data[0] !== 32'h11223344) begin
                errors++; $display("FAIL abort_recv_wr0: got %h:%h want 00:11223344",
                                   wr_addr[0], wr_data[0]);
            end
        end
    endtask

    task automatic test_abort_write();
        clear_mon();
        start_load(2);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL abort_wr_accept_err: got %b want 0", err);
        end
        send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
        load_abort = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL abort_wr_we: got %b want 0", mem_we);
        end
        step();
        load_abort = 1'b0;
        checks++;
        if ({busy, err} !== 2'b01) begin
            errors++; $display("FAIL abort_wr_idle: busy/err got %b want 01", {busy, err});
        end
        step();
        checks++;
        if (wr_addr.size() !== 0 || done_cnt !== 0) begin
            errors++; $display("FAIL abort_wr_none: writes %0d done %0d want 0 0",
                               wr_addr.size(), done_cnt);
        end
    endtask

    task automatic test_reset_midload();
        clear_mon();
        start_load(2);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        send_byte(8'h01, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({byte_ready, mem_we, cpu_stall, cpu_pc_reset, busy, done, err} !== 7'b0 ||
            mem_waddr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: ctrl %b addr %h data %h want 0",
                               {byte_ready, mem_we, cpu_stall, cpu_pc_reset, busy, done, err},
                               mem_waddr, mem_wdata);
        end
        step();
        rst = 1'b0;
        step();
        clear_mon();
        start_load(1);
        send_byte(8'hAE, 0); send_byte(8'h0A, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(8'hA4, 0);
`else
        step();
`endif
        step();
        checks++;
        if (wr_addr.size() !== 1 || done_cnt !== 1 || err !== 1'b0) begin
            errors++; $display("FAIL rst_reload: writes %0d done %0d err %b want 1 1 0",
                               wr_addr.size(), done_cnt, err);
        end else begin
            checks++;
            if (wr_addr[0] !== 7'd0 || wr_data[0] !== 32'hAE0A0000) begin
                errors++; $display("FAIL rst_reload_wr: got %h:%h want 00:ae0a0000",
                                   wr_addr[0], wr_data[0]);
            end
        end
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        clear_mon();
        start_load(1);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
        send_byte(8'h2F, 0);
        checks++;
        if ({done, cpu_pc_reset} !== 2'b11) begin
            errors++; $display("FAIL cksum_good: done/pcr got %b want 11", {done, cpu_pc_reset});
        end
        step();
        clear_mon();
        start_load(1);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
        send_byte(8'h00, 0);
        checks++;
        if ({err, cpu_stall, busy} !== 3'b100) begin
            errors++; $display("FAIL cksum_bad: err/stall/busy got %b want 100",
                               {err, cpu_stall, busy});
        end
        repeat (2) step();
        checks++;
        if (pcr_cnt !== 0 || done_cnt !== 0) begin
            errors++; $display("FAIL cksum_bad_pulses: pcr %0d done %0d want 0 0", pcr_cnt, done_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_illegal();
        test_full_depth();
        test_abort_recv();
        test_abort_write();
        test_reset_midload();
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
